// File: rtl/param_reg_file_if.sv
// ---------------------------------------------------------------------------
// param_reg_file_if
//   Bundles the write, read and status signals of param_reg_file.
//   master : control side (drives write/read requests, receives operands)
//   slave  : register file side
// Signals
//   Wr_en, Wr_wide, Wr_addr[ADDR_W], Wr_data[2*DATA_W]   write request
//   Rd_en, Aaddr[ADDR_W], Baddr[ADDR_W]                  read request
//   Imm_sel, Imm_val[IMM_W]                              operand B immediate
//   OperandA[DATA_W], OperandB[DATA_W], Ready            results / status
// ---------------------------------------------------------------------------
interface param_reg_file_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int IMM_W  = 4
);
  logic                Wr_en;
  logic                Wr_wide;
  logic [ADDR_W-1:0]   Wr_addr;
  logic [2*DATA_W-1:0] Wr_data;
  logic                Rd_en;
  logic [ADDR_W-1:0]   Aaddr;
  logic [ADDR_W-1:0]   Baddr;
  logic                Imm_sel;
  logic [IMM_W-1:0]    Imm_val;
  logic [DATA_W-1:0]   OperandA;
  logic [DATA_W-1:0]   OperandB;
  logic                Ready;

  modport master (
    output Wr_en, Wr_wide, Wr_addr, Wr_data, Rd_en, Aaddr, Baddr, Imm_sel, Imm_val,
    input  OperandA, OperandB, Ready
  );

  modport slave (
    input  Wr_en, Wr_wide, Wr_addr, Wr_data, Rd_en, Aaddr, Baddr, Imm_sel, Imm_val,
    output OperandA, OperandB, Ready
  );
endinterface

// File: rtl/param_reg_file.sv
// ---------------------------------------------------------------------------
// param_reg_file
//   Two-read/one-write register file feeding the ALU. Registered operand
//   outputs, zero-extended immediate path for operand B, and a double-width
//   write that lands in a fixed HI/LO register pair. After reset a clear
//   sequencer zeroes every register (one per clock) before Ready asserts.
//   Register 0 always reads 0 and ignores writes.
// Ports
//   CLK_In  : clock, all state changes on its rising edge
//   RST_In  : synchronous active-high reset (restarts the clear sequence)
//   bus     : param_reg_file_if.slave (write/read requests, operands, Ready)
// Build option
//   PARAM_REG_FILE_BYPASS_EN : when defined, a read of a register written on
//   the same edge returns the new value (RUN only). Undefined: old value.
// ---------------------------------------------------------------------------
module param_reg_file #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int IMM_W   = 4,
  parameter int HI_ADDR = 15,
  parameter int LO_ADDR = 14
) (
  input  logic              CLK_In,
  input  logic              RST_In,
  param_reg_file_if.slave   bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   op_a_q, op_a_d;
  logic [DATA_W-1:0]   op_b_q, op_b_d;
  logic [DATA_W-1:0]   regs_q [DEPTH];

  // Per-register write strobe and data for this edge (clear or functional).
  logic [DEPTH-1:0]    wr_hit;
  logic [DATA_W-1:0]   wr_val [DEPTH];

  logic                run_wr;
  logic [DATA_W-1:0]   wr_hi;
  logic [DATA_W-1:0]   wr_lo;
  logic [DATA_W-1:0]   rd_a;
  logic [DATA_W-1:0]   rd_b;
  logic [DATA_W-1:0]   imm_ext;

  assign run_wr  = (state_q == S_RUN) && bus.Wr_en;
  assign wr_hi   = bus.Wr_data[2*DATA_W-1:DATA_W];
  assign wr_lo   = bus.Wr_data[DATA_W-1:0];
  assign imm_ext = DATA_W'(bus.Imm_val);

  // Write decode, one slice per register. Register 0 is never written so it
  // can be read as a constant zero.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr
    if (gi == 0) begin : g_zero
      assign wr_hit[gi] = 1'b0;
      assign wr_val[gi] = '0;
    end else begin : g_reg
      logic init_hit;
      logic hi_hit;
      logic lo_hit;
      logic nar_hit;
      assign init_hit = (state_q == S_INIT) && (clr_cnt_q == ADDR_W'(gi));
      assign hi_hit   = run_wr && bus.Wr_wide && (gi == HI_ADDR);
      assign lo_hit   = run_wr && bus.Wr_wide && (gi == LO_ADDR);
      assign nar_hit  = run_wr && !bus.Wr_wide && (bus.Wr_addr == ADDR_W'(gi));
      assign wr_hit[gi] = init_hit | hi_hit | lo_hit | nar_hit;
      // Clear wins, then the HI half; LO half and narrow data share wr_lo.
      assign wr_val[gi] = init_hit ? '0 : (hi_hit ? wr_hi : wr_lo);
    end
  end

  // Read ports (combinational view of the array, registered into operands).
  always_comb begin
    rd_a = regs_q[bus.Aaddr];
    rd_b = regs_q[bus.Baddr];
`ifdef PARAM_REG_FILE_BYPASS_EN
    if ((state_q == S_RUN) && wr_hit[bus.Aaddr]) rd_a = wr_val[bus.Aaddr];
    if ((state_q == S_RUN) && wr_hit[bus.Baddr]) rd_b = wr_val[bus.Baddr];
`endif
    if (bus.Aaddr == '0) rd_a = '0;
    if (bus.Baddr == '0) rd_b = '0;
  end

  // Next-state / output logic.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ready_d   = ready_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    case (state_q)
      S_INIT: begin
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        op_a_d    = '0;
        op_b_d    = '0;
        if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = S_RUN;
          ready_d = 1'b1;
        end
      end
      S_RUN: begin
        if (bus.Rd_en) begin
          op_a_d = rd_a;
          op_b_d = bus.Imm_sel ? imm_ext : rd_b;
        end
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  always_ff @(posedge CLK_In) begin
    if (RST_In) begin
      state_q   <= S_INIT;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
      op_a_q    <= '0;
      op_b_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= ready_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_hit[i]) regs_q[i] <= wr_val[i];
      end
    end
  end

  assign bus.OperandA = op_a_q;
  assign bus.OperandB = op_b_q;
  assign bus.Ready    = ready_q;

endmodule
